cpld1_ctrl: RTL and testbench

//  One node of a chained cursor-passing game built from several CPLDs.
//  The node owns a 5-position local segment (pos 0..4, 0 = leftmost). While it holds
//  the cursor, the buttons move it left and right. Moving left past position 0 hands
//  the cursor to the left neighbour over left_in. A cursor arriving from the right

---
 rtl/cpld1_ctrl.sv | 152 +++++++++++++++
 tb/tb_cpld1_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpld1_ctrl.sv
// cpld1_ctrl -- one node of a chained cursor-passing game.
//
// The node owns a local segment of NPOS cursor positions (0 = leftmost).
// While it holds the cursor, the buttons move it left and right. Moving left
// past position 0 hands the cursor to the left neighbour. A cursor can also
// arrive from the right neighbour. The node also produces a display
// digit-select scan that advances on fastClk ticks.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   resetbutton  in   synchronous active-high reset
//   left_in      out  [4]=valid, [3]=0, [2:0]=entry pos, sent to the left neighbour
//   right_out2   in   message from the right neighbour, same format (asynchronous)
//   fastClk      in   scan tick, sampled as data (not a clock)
//   leftbutton   in   move-left request (asynchronous level)
//   rightbutton  in   move-right request (asynchronous level)
//   pos_c        out  cursor position when active, 3'b111 when inactive (registered)
//   sel          out  display digit select, cycles 0..NPOS-1
//
// Handshake note: there is no ready signal. A message is valid while bit [4]
// is high. The receiver acts once, on the rising edge of the synchronised
// valid bit. A sender must hold the message stable for at least 4 clk cycles,
// so the synchronised data bits are settled when that edge is seen.
module cpld1_ctrl #(
    parameter int NPOS     = 5,
    parameter int RST_POS  = 2,
    parameter int HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       resetbutton,
    output logic [4:0] left_in,
    input  logic [4:0] right_out2,
    input  logic       fastClk,
    input  logic       leftbutton,
    input  logic       rightbutton,
    output logic [2:0] pos_c,
    output logic [2:0] sel
);

    localparam logic [2:0] MAX_POS   = 3'(NPOS - 1);
    localparam logic [2:0] INIT_POS  = 3'(RST_POS);
    localparam logic [2:0] HOLD_INIT = 3'(HOLD_CYC - 1);
    localparam logic [4:0] HANDOFF   = {1'b1, 1'b0, MAX_POS};

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Bit 3 of the inbound message is always zero and carries no information.
    logic unused_bit3;
    assign unused_bit3 = right_out2[3];

    // Synchronizer chains: bit0 = s1, bit1 = s2, bit2 = s3 (edge-detect delay).
    logic [2:0] lb_sync, rb_sync, fc_sync, rv_sync;
    logic [2:0] rd_s1, rd_s2;

    logic lb_pulse, rb_pulse, fc_pulse, rv_pulse;
    assign lb_pulse = lb_sync[1] & ~lb_sync[2];
    assign rb_pulse = rb_sync[1] & ~rb_sync[2];
    assign fc_pulse = fc_sync[1] & ~fc_sync[2];
    assign rv_pulse = rv_sync[1] & ~rv_sync[2];

    always_ff @(posedge clk) begin
        if (resetbutton) begin
            lb_sync <= '0;
            rb_sync <= '0;
            fc_sync <= '0;
            rv_sync <= '0;
            rd_s1   <= '0;
            rd_s2   <= '0;
        end else begin
            lb_sync <= {lb_sync[1:0], leftbutton};
            rb_sync <= {rb_sync[1:0], rightbutton};
            fc_sync <= {fc_sync[1:0], fastClk};
            rv_sync <= {rv_sync[1:0], right_out2[4]};
            rd_s1   <= right_out2[2:0];
            rd_s2   <= rd_s1;
        end
    end

    state_t     state, state_nx;
    logic [2:0] pos, pos_nx;
    logic [2:0] hold_cnt, hold_nx;
    logic [4:0] left_in_nx;
    logic [2:0] sel_nx;
    logic [2:0] pos_c_nx;

    always_ff @(posedge clk) begin
        if (resetbutton) begin
            state    <= ST_ACTIVE;
            pos      <= INIT_POS;
            hold_cnt <= '0;
            left_in  <= '0;
            sel      <= '0;
            pos_c    <= INIT_POS;
        end else begin
            state    <= state_nx;
            pos      <= pos_nx;
            hold_cnt <= hold_nx;
            left_in  <= left_in_nx;
            sel      <= sel_nx;
            pos_c    <= pos_c_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pos_nx     = pos;
        hold_nx    = hold_cnt;
        left_in_nx = left_in;
        sel_nx     = sel;

        // Outbound message countdown: the message stays up while the counter
        // runs down, and is dropped on the edge after it reaches zero.
        if (hold_cnt != 3'd0) begin
            hold_nx = hold_cnt - 3'd1;
        end else begin
            left_in_nx = '0;
        end

        if (fc_pulse) begin
            sel_nx = (sel == MAX_POS) ? 3'd0 : sel + 3'd1;
        end

        case (state)
            ST_ACTIVE: begin
                // Simultaneous left and right pulses cancel each other.
                if (lb_pulse && !rb_pulse) begin
                    if (pos != 3'd0) begin
                        pos_nx = pos - 3'd1;
                    end else begin
                        state_nx   = ST_IDLE;
                        left_in_nx = HANDOFF;
                        hold_nx    = HOLD_INIT;
                    end
                end else if (rb_pulse && !lb_pulse && pos != MAX_POS) begin
                    pos_nx = pos + 3'd1;
                end
            end
            default: begin
                if (rv_pulse) begin
                    state_nx = ST_ACTIVE;
                    pos_nx   = (rd_s2 > MAX_POS) ? MAX_POS : rd_s2;
                end
            end
        endcase

        pos_c_nx = (state_nx == ST_ACTIVE) ? pos_nx : 3'b111;
    end

endmodule

// File: tb/tb_cpld1_ctrl.sv
module tb_cpld1_ctrl;

  logic       clk;
  logic       resetbutton;
  logic [4:0] left_in;
  logic [4:0] right_out2;
  logic       fastClk;
  logic       leftbutton;
  logic       rightbutton;
  logic [2:0] pos_c;
  logic [2:0] sel;

  int checks;
  int failures;

  cpld1_ctrl dut (
    .clk        (clk),
    .resetbutton(resetbutton),
    .left_in    (left_in),
    .right_out2 (right_out2),
    .fastClk    (fastClk),
    .leftbutton (leftbutton),
    .rightbutton(rightbutton),
    .pos_c      (pos_c),
    .sel        (sel)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetbutton = 1'b1;
    tick(1);
    resetbutton = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Hold a button for 3 edges (action lands on the 3rd), then release and
  // let the synchronizer drain.
  task automatic press_left();
    leftbutton = 1'b1;
    tick(3);
    leftbutton = 1'b0;
    tick(3);
  endtask

  task automatic press_right();
    rightbutton = 1'b1;
    tick(3);
    rightbutton = 1'b0;
    tick(3);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [2:0] exp_sel[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    do_reset();
    checks++;
    if (pos_c !== 3'd2) begin
      failures++;
      $display("FAIL reset_pos_c got=%0d exp=2", pos_c);
    end
    checks++;
    if (sel !== 3'd0) begin
      failures++;
      $display("FAIL reset_sel got=%0d exp=0", sel);
    end
    checks++;
    if (left_in !== 5'b0) begin
      failures++;
      $display("FAIL reset_left_in got=%b exp=00000", left_in);
    end
    for (int i = 0; i < 5; i++) begin
      fastClk = 1'b1;
      tick(3);
      checks++;
      if (sel !== exp_sel[i]) begin
        failures++;
        $display("FAIL scan_sel[%0d] got=%0d exp=%0d", i, sel, exp_sel[i]);
      end
      fastClk = 1'b0;
      tick(3);
    end
  endtask

  task automatic test_move();
    logic [2:0] exp_pos[3] = '{3'd3, 3'd4, 3'd4};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press_right();
      checks++;
      if (pos_c !== exp_pos[i]) begin
        failures++;
        $display("FAIL move_right[%0d] got=%0d exp=%0d", i, pos_c, exp_pos[i]);
      end
    end
    press_left();
    checks++;
    if (pos_c !== 3'd3) begin
      failures++;
      $display("FAIL move_left got=%0d exp=3", pos_c);
    end
  endtask

  task automatic test_handoff_out();
    do_reset();
    press_left();
    press_left();
    checks++;
    if (pos_c !== 3'd0) begin
      failures++;
      $display("FAIL at_pos0 got=%0d exp=0", pos_c);
    end
    leftbutton = 1'b1;
    tick(3);
    checks++;
    if (pos_c !== 3'b111) begin
      failures++;
      $display("FAIL handoff_pos_c got=%0d exp=7", pos_c);
    end
    // Message must be visible for exactly four cycles.
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (left_in !== 5'b10100) begin
        failures++;
        $display("FAIL handoff_hold[%0d] got=%b exp=10100", i, left_in);
      end
      if (i < 3) tick(1);
    end
    leftbutton = 1'b0;
    tick(1);
    checks++;
    if (left_in !== 5'b0) begin
      failures++;
      $display("FAIL handoff_release got=%b exp=00000", left_in);
    end
    tick(2);
    press_right();
    press_left();
    checks++;
    if (pos_c !== 3'b111) begin
      failures++;
      $display("FAIL inactive_buttons got=%0d exp=7", pos_c);
    end
    checks++;
    if (left_in !== 5'b0) begin
      failures++;
      $display("FAIL inactive_left_in got=%b exp=00000", left_in);
    end
  endtask

  task automatic send_msg(input logic [4:0] msg, input logic [2:0] exp, input string name);
    right_out2 = msg;
    tick(3);
    checks++;
    if (pos_c !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, pos_c, exp);
    end
    tick(1);
    right_out2 = 5'b0;
    tick(3);
  endtask

  task automatic test_handoff_in();
    // Node is inactive after test_handoff_out.
    send_msg(5'b10011, 3'd3, "inbound_pos3");
    press_left();
    press_left();
    press_left();
    press_left();
    tick(5);
    checks++;
    if (pos_c !== 3'b111 || left_in !== 5'b0) begin
      failures++;
      $display("FAIL reinactive got pos_c=%0d left_in=%b exp pos_c=7 left_in=00000", pos_c, left_in);
    end
    send_msg(5'b10111, 3'd4, "inbound_clamp");
    send_msg(5'b10000, 3'd4, "inbound_while_active");
  endtask

  task automatic test_back_to_back();
    // Cursor is at 4 and active.
    leftbutton  = 1'b1;
    rightbutton = 1'b1;
    tick(3);
    checks++;
    if (pos_c !== 3'd4) begin
      failures++;
      $display("FAIL both_buttons got=%0d exp=4", pos_c);
    end
    leftbutton  = 1'b0;
    rightbutton = 1'b0;
    tick(3);
    leftbutton = 1'b1;
    tick(100);
    leftbutton = 1'b0;
    tick(3);
    checks++;
    if (pos_c !== 3'd3) begin
      failures++;
      $display("FAIL long_hold got=%0d exp=3", pos_c);
    end
  endtask

  task automatic test_reset_mid_handoff();
    // From 3: three lefts reach 0, a fourth starts the handoff.
    press_left();
    press_left();
    press_left();
    leftbutton = 1'b1;
    tick(4);
    checks++;
    if (left_in !== 5'b10100) begin
      failures++;
      $display("FAIL mid_handoff_msg got=%b exp=10100", left_in);
    end
    leftbutton = 1'b0;
    do_reset();
    checks++;
    if (left_in !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_left_in got=%b exp=00000", left_in);
    end
    checks++;
    if (pos_c !== 3'd2) begin
      failures++;
      $display("FAIL reset_mid_pos_c got=%0d exp=2", pos_c);
    end
  endtask

  // ---------------- main / report ----------------
  initial begin
    checks      = 0;
    failures    = 0;
    resetbutton = 1'b0;
    right_out2  = 5'b0;
    fastClk     = 1'b0;
    leftbutton  = 1'b0;
    rightbutton = 1'b0;
    tick(1);

    test_reset();
    test_move();
    test_handoff_out();
    test_handoff_in();
    test_back_to_back();
    test_reset_mid_handoff();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
